axi_pcie_slave_mem: RTL
=======================

Name: axi_pcie_slave_mem

Overview:
- AXI4 responder (slave) for the 256-bit PCIe AXI fabric. It is the far end of the PCIe master block's single-beat and burst read/write transactions.
- Backs the AXI address space with an internal DEPTH x 256-bit memory.
- Generates the fabric's per-byte odd parity on R/B channels and checks incoming W parity.
- Sits on the PCIe core's slave AXI port, or in loopback against the master block for bring-up.

Parameters:
AW, 8, memory index width; DEPTH = 2**AW 256-bit words
ERR_ON_SIZE, 1, 1: AxSIZE != 5 answered SLVERR, beat not written

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
state  out  8  {4'b0, rd_state[1:0], wr_state[1:0]} debug
S_AXI_AWADDR  in  64  write address (byte)
S_AXI_AWID  in  8  write ID
S_AXI_AWLEN  in  8  beats-1
S_AXI_AWSIZE  in  3  must be 5
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake
S_AXI_WDATA  in  256  write data
S_AXI_WDATA_PAR  in  32  per-byte parity, bit i = ~^WDATA[8i+:8]
S_AXI_WSTRB  in  32  byte enables
S_AXI_WLAST  in  1  last beat
S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake
S_AXI_BID  out  8  write response ID
S_AXI_BID_PAR  out  1  ~^BID
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR
S_AXI_BRESP_PAR  out  1  ~^BRESP
S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake
S_AXI_ARADDR  in  64  read address
S_AXI_ARID  in  8  read ID
S_AXI_ARLEN  in  8  beats-1
S_AXI_ARSIZE  in  3  must be 5
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake
S_AXI_RDATA  out  256  read data
S_AXI_RDATA_PAR  out  32  bit i = ~^RDATA[8i+:8]
S_AXI_RID  out  8  read ID
S_AXI_RID_PAR  out  1  ~^RID
S_AXI_RRESP  out  2  read response
S_AXI_RRESP_PAR  out  1  ~^RRESP
S_AXI_RLAST  out  1  last read beat
S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake
par_err_cnt  out  16  W-parity-error beat count, saturating

Behaviour:
- Reset (rst high at clk edge):
  - All READY/VALID low, BRESP/RRESP/RLAST/BID/RID/RDATA 0, par_err_cnt 0, both FSMs idle.
  - Memory contents are not cleared.
  - Reset mid-burst abandons the transaction with no response.
  - Parity outputs are combinational from the registered fields, so BID_PAR=1, BRESP_PAR=1, RDATA_PAR=32'hFFFFFFFF in reset.
- Word index = ADDR[AW+4:5]; ADDR[4:0] ignored. ADDR[63:AW+5] != 0 means out of window and gives DECERR.
- Write FSM:
  - WR_IDLE:
    - AWREADY=1.
    - On AW handshake, latch ID, index, LEN, and err := DECERR/SLVERR (size check).
    - AWREADY drops the same edge; go to WR_DATA.
  - WR_DATA:
    - WREADY=1.
    - Each W handshake writes bytes with WSTRB[i]=1 at index, only if err==OKAY and the beat's parity is clean.
    - Any byte with WDATA_PAR[i] != ~^byte drops the whole beat, sets err=SLVERR (unless already DECERR), and increments par_err_cnt.
    - Index += 1 mod DEPTH (wraps).
    - Beat counter runs 0..LEN. On beat LEN, go to WR_RESP.
    - If WLAST disagrees with the counter (early or missing), set SLVERR.
    - Extra W beats after LEN are not accepted: WREADY is 0 outside WR_DATA.
  - WR_RESP:
    - BVALID=1 with latched BID/err.
    - On BREADY go to WR_IDLE. BVALID holds stable until accepted.
- Read FSM:
  - RD_IDLE:
    - ARREADY=1.
    - On AR handshake, latch fields and err; go to RD_FETCH.
  - RD_FETCH:
    - One-cycle synchronous memory read; go to RD_DATA.
  - RD_DATA:
    - RVALID=1 with RDATA = mem[index], or 0 if err != OKAY.
    - RRESP = err; RLAST = (beat==LEN).
    - Outputs hold while RVALID && !RREADY.
    - On handshake: if last, go to RD_IDLE; else index += 1 mod DEPTH and go to RD_FETCH.
  - First-beat latency: AR handshake edge +2 cycles to RVALID; throughput is 1 beat per 2 cycles.
- Read and write FSMs run concurrently (dual-port memory).
  - Same-cycle write and read to the same word: the read returns old data.
- par_err_cnt saturates at 16'hFFFF.

Test Plan:
1. Single write AWADDR=0x40, AWLEN=0, WDATA=256'h1122..FF, WSTRB=FFFFFFFF, correct parity -> BRESP=00, BID=AWID=0x07, BID_PAR=0. Then a read of 0x40 returns the same data, RLAST=1, RRESP=00, RDATA_PAR matches per byte.
2. 4-beat write at index DEPTH-2 (AWADDR=(DEPTH-2)<<5, LEN=3), then a 4-beat read -> beats land at indices 254, 255, 0, 1 for AW=8; readback matches; RLAST only on beat 3.
3. Write WSTRB=32'h0000000F over a word of all 0xAA -> bytes 0..3 become new data, bytes 4..31 stay 0xAA.
4. Flip WDATA_PAR[5] on beat 1 of a 2-beat write -> beat 1 not written, BRESP=10, par_err_cnt=1.
5. AWADDR=64'h1_0000_0000 -> BRESP=11, memory unchanged. ARADDR same with ARLEN=1 -> 2 beats of RDATA=0, RRESP=11.
6. Hold RREADY=0 for 5 cycles on beat 0 -> RVALID/RDATA/RLAST stable. Also assert rst mid-burst -> all VALIDs 0 next cycle and a new AW is accepted cleanly.

Source files
------------

// File: rtl/axi_pcie_slave_mem.sv
// AXI4 responder for the 256-bit PCIe fabric, backed by a DEPTH x 256-bit
// dual-port memory, with per-byte odd parity generated on R/B and checked on W.
module axi_pcie_slave_mem #(
  parameter int unsigned AW          = 8,
  parameter bit          ERR_ON_SIZE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  output logic [7:0]   state,
  input  logic [63:0]  S_AXI_AWADDR,
  input  logic [7:0]   S_AXI_AWID,
  input  logic [7:0]   S_AXI_AWLEN,
  input  logic [2:0]   S_AXI_AWSIZE,
  input  logic         S_AXI_AWVALID,
  output logic         S_AXI_AWREADY,
  input  logic [255:0] S_AXI_WDATA,
  input  logic [31:0]  S_AXI_WDATA_PAR,
  input  logic [31:0]  S_AXI_WSTRB,
  input  logic         S_AXI_WLAST,
  input  logic         S_AXI_WVALID,
  output logic         S_AXI_WREADY,
  output logic [7:0]   S_AXI_BID,
  output logic         S_AXI_BID_PAR,
  output logic [1:0]   S_AXI_BRESP,
  output logic         S_AXI_BRESP_PAR,
  output logic         S_AXI_BVALID,
  input  logic         S_AXI_BREADY,
  input  logic [63:0]  S_AXI_ARADDR,
  input  logic [7:0]   S_AXI_ARID,
  input  logic [7:0]   S_AXI_ARLEN,
  input  logic [2:0]   S_AXI_ARSIZE,
  input  logic         S_AXI_ARVALID,
  output logic         S_AXI_ARREADY,
  output logic [255:0] S_AXI_RDATA,
  output logic [31:0]  S_AXI_RDATA_PAR,
  output logic [7:0]   S_AXI_RID,
  output logic         S_AXI_RID_PAR,
  output logic [1:0]   S_AXI_RRESP,
  output logic         S_AXI_RRESP_PAR,
  output logic         S_AXI_RLAST,
  output logic         S_AXI_RVALID,
  input  logic         S_AXI_RREADY,
  output logic [15:0]  par_err_cnt
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned HI_W  = 64 - AW - 5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_DATA  = 2'd2
  } rd_state_t;

  function automatic logic [1:0] req_err(input logic [HI_W-1:0] hi, input logic [2:0] size);
    logic [1:0] e;
    e = RESP_OKAY;
    if (hi != '0) e = RESP_DECERR;
    else if (ERR_ON_SIZE && (size != 3'd5)) e = RESP_SLVERR;
    return e;
  endfunction

  logic [255:0] mem [DEPTH];

  // Byte offset within a word carries no meaning on this fabric.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{S_AXI_AWADDR[4:0], S_AXI_ARADDR[4:0]};

  // ---------------- write channel ----------------
  wr_state_t       wr_state_q, wr_state_d;
  logic [7:0]      wr_id_q, wr_id_d;
  logic [AW-1:0]   wr_idx_q, wr_idx_d;
  logic [7:0]      wr_len_q, wr_len_d;
  logic [7:0]      wr_beat_q, wr_beat_d;
  logic [1:0]      wr_err_q, wr_err_d;
  logic [15:0]     par_err_cnt_q, par_err_cnt_d;
  logic            w_par_bad;
  logic            w_hs;
  logic            mem_we;

  always_comb begin
    wr_state_d    = wr_state_q;
    wr_id_d       = wr_id_q;
    wr_idx_d      = wr_idx_q;
    wr_len_d      = wr_len_q;
    wr_beat_d     = wr_beat_q;
    wr_err_d      = wr_err_q;
    par_err_cnt_d = par_err_cnt_q;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    w_hs          = 1'b0;
    mem_we        = 1'b0;
    w_par_bad     = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (S_AXI_WDATA_PAR[i] != ~^S_AXI_WDATA[8*i +: 8]) w_par_bad = 1'b1;
    end

    case (wr_state_q)
      WR_IDLE: begin
        S_AXI_AWREADY = !rst;
        if (S_AXI_AWVALID && !rst) begin
          wr_id_d    = S_AXI_AWID;
          wr_idx_d   = S_AXI_AWADDR[AW+4:5];
          wr_len_d   = S_AXI_AWLEN;
          wr_beat_d  = 8'd0;
          wr_err_d   = req_err(S_AXI_AWADDR[63:AW+5], S_AXI_AWSIZE);
          wr_state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        S_AXI_WREADY = !rst;
        w_hs         = S_AXI_WVALID && !rst;
        if (w_hs) begin
          // The write gate uses the error seen before this beat; a fault
          // found on this beat only affects the response and later beats.
          mem_we = (wr_err_q == RESP_OKAY) && !w_par_bad;
          if (w_par_bad) begin
            if (wr_err_q != RESP_DECERR) wr_err_d = RESP_SLVERR;
            if (par_err_cnt_q != 16'hFFFF) par_err_cnt_d = par_err_cnt_q + 16'd1;
          end
          if ((S_AXI_WLAST != (wr_beat_q == wr_len_q)) && (wr_err_q != RESP_DECERR))
            wr_err_d = RESP_SLVERR;
          wr_idx_d  = wr_idx_q + AW'(1);
          wr_beat_d = wr_beat_q + 8'd1;
          if (wr_beat_q == wr_len_q) wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q    <= WR_IDLE;
      wr_id_q       <= '0;
      wr_idx_q      <= '0;
      wr_len_q      <= '0;
      wr_beat_q     <= '0;
      wr_err_q      <= RESP_OKAY;
      par_err_cnt_q <= '0;
    end else begin
      wr_state_q    <= wr_state_d;
      wr_id_q       <= wr_id_d;
      wr_idx_q      <= wr_idx_d;
      wr_len_q      <= wr_len_d;
      wr_beat_q     <= wr_beat_d;
      wr_err_q      <= wr_err_d;
      par_err_cnt_q <= par_err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 32; i++) begin
        if (S_AXI_WSTRB[i]) mem[wr_idx_q][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  rd_state_t       rd_state_q, rd_state_d;
  logic [7:0]      rd_id_q, rd_id_d;
  logic [AW-1:0]   rd_idx_q, rd_idx_d;
  logic [7:0]      rd_len_q, rd_len_d;
  logic [7:0]      rd_beat_q, rd_beat_d;
  logic [1:0]      rd_err_q, rd_err_d;
  logic [255:0]    rdata_q, rdata_d;

  always_comb begin
    rd_state_d    = rd_state_q;
    rd_id_d       = rd_id_q;
    rd_idx_d      = rd_idx_q;
    rd_len_d      = rd_len_q;
    rd_beat_d     = rd_beat_q;
    rd_err_d      = rd_err_q;
    rdata_d       = rdata_q;
    S_AXI_ARREADY = 1'b0;

    case (rd_state_q)
      RD_IDLE: begin
        S_AXI_ARREADY = !rst;
        if (S_AXI_ARVALID && !rst) begin
          rd_id_d    = S_AXI_ARID;
          rd_idx_d   = S_AXI_ARADDR[AW+4:5];
          rd_len_d   = S_AXI_ARLEN;
          rd_beat_d  = 8'd0;
          rd_err_d   = req_err(S_AXI_ARADDR[63:AW+5], S_AXI_ARSIZE);
          rd_state_d = RD_FETCH;
        end
      end
      RD_FETCH: begin
        // Registered read: a write landing on this same edge is not seen.
        rdata_d    = (rd_err_q == RESP_OKAY) ? mem[rd_idx_q] : '0;
        rd_state_d = RD_DATA;
      end
      RD_DATA: begin
        if (S_AXI_RREADY) begin
          if (rd_beat_q == rd_len_q) begin
            rd_state_d = RD_IDLE;
          end else begin
            rd_idx_d   = rd_idx_q + AW'(1);
            rd_beat_d  = rd_beat_q + 8'd1;
            rd_state_d = RD_FETCH;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      rd_id_q    <= '0;
      rd_idx_q   <= '0;
      rd_len_q   <= '0;
      rd_beat_q  <= '0;
      rd_err_q   <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_id_q    <= rd_id_d;
      rd_idx_q   <= rd_idx_d;
      rd_len_q   <= rd_len_d;
      rd_beat_q  <= rd_beat_d;
      rd_err_q   <= rd_err_d;
      rdata_q    <= rdata_d;
    end
  end

  // ---------------- outputs ----------------
  assign state           = {4'b0000, rd_state_q, wr_state_q};
  assign par_err_cnt     = par_err_cnt_q;

  assign S_AXI_BID       = wr_id_q;
  assign S_AXI_BID_PAR   = ~^wr_id_q;
  assign S_AXI_BRESP     = wr_err_q;
  assign S_AXI_BRESP_PAR = ~^wr_err_q;

  assign S_AXI_RVALID    = (rd_state_q == RD_DATA);
  assign S_AXI_RLAST     = (rd_state_q == RD_DATA) && (rd_beat_q == rd_len_q);
  assign S_AXI_RDATA     = rdata_q;
  assign S_AXI_RID       = rd_id_q;
  assign S_AXI_RID_PAR   = ~^rd_id_q;
  assign S_AXI_RRESP     = rd_err_q;
  assign S_AXI_RRESP_PAR = ~^rd_err_q;

  always_comb begin
    S_AXI_RDATA_PAR = '0;
    for (int unsigned i = 0; i < 32; i++) S_AXI_RDATA_PAR[i] = ~^rdata_q[8*i +: 8];
  end

endmodule
